// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated CPU data memory with byte/halfword/word access
// and a sticky error flag for misaligned or reserved-size accesses.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    output logic        ACKD_n,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          bad_q, bad_d;
    logic          err_q, err_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          bad_in, mem_we;
    logic [4:0]    sh;
    logic [31:0]   rd_word, shifted, rdata, mask, new_word;
    logic          unused_addr;

    assign unused_addr = ^DAD[31:AW+2];
    assign bad_in = (SIZE == 2'b11) || (SIZE == 2'b01 && DAD[0]) || (SIZE == 2'b00 && DAD[1:0] != 2'b00);
    assign sh = {addr_q[1:0], 3'b000};
    assign rd_word = mem[addr_q[AW+1:2]];
    assign shifted = rd_word >> sh;
    assign rdata = bad_q ? 32'h0 :
                   size_q == 2'b10 ? {24'h0, shifted[7:0]} :
                   size_q == 2'b01 ? {16'h0, shifted[15:0]} : shifted;
    assign mask = size_q == 2'b10 ? 32'h0000_00FF << sh :
                  size_q == 2'b01 ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
    assign new_word = (rd_word & ~mask) | ((wdata_q << sh) & mask);
    // A write lands on the edge leaving ACK, so a reset during the transaction drops it
    assign mem_we = state_q == S_ACK && wr_q && !bad_q && !rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        bad_d   = bad_q;
        err_d   = err_q;
        if (state_q == S_IDLE && MREQ) begin
            addr_d  = DAD[AW+1:0];
            wr_d    = WRITE;
            size_d  = SIZE;
            wdata_d = DDT;
            bad_d   = bad_in;
            err_d   = err_q | bad_in;
            state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
        end else if (state_q == S_WAIT) begin
            cnt_d   = (cnt_q == W_LAST) ? 4'd0 : cnt_q + 4'd1;
            state_d = (cnt_q == W_LAST) ? S_ACK : S_WAIT;
        end else if (state_q == S_ACK) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
        addr_q  <= addr_d;
        wr_q    <= wr_d;
        size_q  <= size_d;
        wdata_q <= wdata_d;
        bad_q   <= bad_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[AW+1:2]] <= new_word;
    end

    assign ACKD_n = state_q != S_ACK;
    assign err    = err_q;
    assign DDT    = (state_q == S_ACK && !wr_q) ? rdata : 32'bz;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait-state cycles inserted before acknowledge (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port DAD  input  32  data address bus from CPU.
REQ-006 SHALL have port DDT  inout  32  data bus: CPU drives write data; block drives read data only in ACK state of a read, else high-Z.
REQ-007 SHALL have port MREQ  input  1  memory request, active high.
REQ-008 SHALL have port WRITE  input  1  1 = write, 0 = read; sampled with MREQ.
REQ-009 SHALL have port SIZE  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-010 SHALL have port ACKD_n  output  1  acknowledge, active low.
REQ-011 SHALL have port err  output  1  sticky access-error flag.

Function
REQ-012 SHALL implement states IDLE, WAIT, ACK.
REQ-013 IDLE: on MREQ=1 SHALL latch DAD, WRITE, SIZE and DDT (write data); go to WAIT if WAIT_CYCLES>0, else ACK.
REQ-014 WAIT: SHALL count WAIT_CYCLES cycles, then go to ACK; MREQ/DAD/DDT changes during WAIT SHALL be ignored.
REQ-015 ACK: SHALL drive ACKD_n=0 for exactly one cycle, then return to IDLE.
REQ-016 Request-to-acknowledge latency SHALL be WAIT_CYCLES+1 cycles (MREQ sample edge to first cycle of ACKD_n=0).
REQ-017 After ACK, IDLE SHALL accept a new request in the next cycle if MREQ=1 (back-to-back, one idle cycle between acks).
REQ-018 Word index SHALL be address bits [log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around aliasing).
REQ-019 Byte ordering SHALL be little-endian: byte lane k = address[1:0]==k.
REQ-020 Write SHALL commit on the edge leaving ACK; byte writes update one lane from DDT[7:0], halfword two lanes from DDT[15:0], word all lanes from DDT[31:0]; untouched lanes preserved.
REQ-021 Read data SHALL be right-justified and zero-extended on DDT during ACK (sign extension is the CPU's job).
REQ-022 Misaligned access (halfword with address[0]=1, word with address[1:0]!=0) or SIZE=11 SHALL still be acknowledged, SHALL NOT modify memory, SHALL return 0 on reads, and SHALL set err.
REQ-023 err SHALL remain 1 until reset.
REQ-024 Read during ACK SHALL reflect memory contents before that cycle's state (no write is in progress concurrently).
REQ-025 DDT SHALL be high-Z in IDLE, WAIT, and ACK of a write.

Reset
REQ-026 With rst=1 at a clock edge: state SHALL become IDLE, wait counter 0, ACKD_n=1, err=0, DDT high-Z.
REQ-027 Reset mid-transaction (WAIT or ACK) SHALL abort it; a pending write SHALL NOT commit; memory contents SHALL NOT be cleared by reset.
REQ-028 rst SHALL take priority over MREQ on the same edge.

Verification
REQ-029 Word write 0xDEADBEEF to 0x100, then word read 0x100, WAIT_CYCLES=2 -> ACKD_n low 3 cycles after each MREQ sample; DDT=0xDEADBEEF in read ACK.
REQ-030 Byte write 0xAA to 0x101 over word 0x11223344 at 0x100, then word read -> 0x1122AA44; byte read 0x101 -> 0x000000AA.
REQ-031 Halfword write 0x5566 to 0x102, halfword read 0x102 -> 0x00005566; halfword read 0x101 -> ack, DDT=0, err=1, memory unchanged.
REQ-032 Aliasing with DEPTH_WORDS=1024: write 0x12345678 to 0x1000, read 0x0000 -> 0x12345678.
REQ-033 Assert rst during WAIT of write 0xFFFFFFFF to 0x200 (previously 0x0) -> no ACK, err=0, later read 0x200 -> 0x00000000.
REQ-034 WAIT_CYCLES=0, MREQ held high for 6 cycles of reads -> ACKD_n pulses every second cycle, DDT high-Z between pulses.
